// File: rtl/ahb3lite_sram_arbiter.sv
// Two-requester round-robin front end issuing single AHB3-Lite word transfers to one SRAM slave.
// GNT one cycle after the request edge, DONE three cycles after it with zero wait states; HREADY=0 stalls the data phase.
module ahb3lite_sram_arbiter #(
  parameter int HADDR_SIZE = 8,
  parameter int HDATA_SIZE = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic [1:0]            REQ,
  input  logic                  WE0,
  input  logic                  WE1,
  input  logic [HADDR_SIZE-1:0] ADDR0,
  input  logic [HADDR_SIZE-1:0] ADDR1,
  input  logic [HDATA_SIZE-1:0] WDATA0,
  input  logic [HDATA_SIZE-1:0] WDATA1,
  output logic [1:0]            GNT,
  output logic [1:0]            DONE,
  output logic [HDATA_SIZE-1:0] RDATA,
  output logic                  ERR,
  output logic                  HSEL,
  output logic [HADDR_SIZE-1:0] HADDR,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [1:0]            HTRANS,
  output logic [HDATA_SIZE-1:0] HWDATA,
  input  logic                  HREADY,
  input  logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HRESP
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  localparam logic [HADDR_SIZE-1:0] WORD_MASK = {{(HADDR_SIZE-2){1'b1}}, 2'b00};

  state_t                  state_q, state_d;
  logic                    sel_q, sel_d;
  logic                    last_q, last_d;
  logic [HDATA_SIZE-1:0]   wdata_q, wdata_d;
  logic [1:0]              gnt_q, gnt_d;
  logic [1:0]              done_q, done_d;
  logic [HDATA_SIZE-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    hsel_q, hsel_d;
  logic [1:0]              htrans_q, htrans_d;
  logic [HADDR_SIZE-1:0]   haddr_q, haddr_d;
  logic                    hwrite_q, hwrite_d;
  logic [HDATA_SIZE-1:0]   hwdata_q, hwdata_d;

  logic                    winner;
  logic                    win_we;
  logic [HADDR_SIZE-1:0]   win_addr;
  logic [HDATA_SIZE-1:0]   win_wdata;

  // Under contention the requester not granted last wins.
  always_comb begin
    winner = REQ[1];
    if (REQ == 2'b11) begin
      winner = ~last_q;
    end
    win_we    = winner ? WE1    : WE0;
    win_addr  = winner ? ADDR1  : ADDR0;
    win_wdata = winner ? WDATA1 : WDATA0;
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    last_d   = last_q;
    wdata_d  = wdata_q;
    gnt_d    = 2'b00;
    done_d   = 2'b00;
    rdata_d  = rdata_q;
    err_d    = err_q;
    hsel_d   = hsel_q;
    htrans_d = htrans_q;
    haddr_d  = haddr_q;
    hwrite_d = hwrite_q;
    hwdata_d = hwdata_q;

    case (state_q)
      S_IDLE: begin
        if (REQ != 2'b00) begin
          sel_d    = winner;
          last_d   = winner;
          gnt_d    = winner ? 2'b10 : 2'b01;
          wdata_d  = win_wdata;
          hsel_d   = 1'b1;
          htrans_d = 2'b10;
          haddr_d  = win_addr & WORD_MASK;
          hwrite_d = win_we;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: begin
        if (HREADY) begin
          hsel_d   = 1'b0;
          htrans_d = 2'b00;
          hwdata_d = wdata_q;
          state_d  = S_DATA;
        end
      end
      S_DATA: begin
        // A stalled data phase (including the first ERROR cycle) leaves every output untouched.
        if (HREADY) begin
          done_d  = sel_q ? 2'b10 : 2'b01;
          err_d   = HRESP;
          if (!hwrite_q) begin
            rdata_d = HRDATA;
          end
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= S_IDLE;
      sel_q    <= 1'b0;
      last_q   <= 1'b1;
      wdata_q  <= '0;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      hsel_q   <= 1'b0;
      htrans_q <= 2'b00;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      hwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      wdata_q  <= wdata_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      hsel_q   <= hsel_d;
      htrans_q <= htrans_d;
      haddr_q  <= haddr_d;
      hwrite_q <= hwrite_d;
      hwdata_q <= hwdata_d;
    end
  end

  assign GNT    = gnt_q;
  assign DONE   = done_q;
  assign RDATA  = rdata_q;
  assign ERR    = err_q;
  assign HSEL   = hsel_q;
  assign HTRANS = htrans_q;
  assign HADDR  = haddr_q;
  assign HWRITE = hwrite_q;
  assign HWDATA = hwdata_q;
  assign HSIZE  = 3'b010;
  assign HBURST = 3'b000;
  assign HPROT  = 4'b0011;

endmodule

// File: tb/tb_ahb3lite_sram_arbiter.sv
// Directed cycle-by-cycle vectors plus hand sequences for round-robin contention and mid-transfer reset.
module tb_ahb3lite_sram_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [1:0]    REQ;
  logic          WE0, WE1;
  logic [AW-1:0] ADDR0, ADDR1;
  logic [DW-1:0] WDATA0, WDATA1;
  logic [1:0]    GNT, DONE;
  logic [DW-1:0] RDATA;
  logic          ERR, HSEL, HWRITE;
  logic [AW-1:0] HADDR;
  logic [2:0]    HSIZE, HBURST;
  logic [3:0]    HPROT;
  logic [1:0]    HTRANS;
  logic [DW-1:0] HWDATA;
  logic          HREADY;
  logic [DW-1:0] HRDATA;
  logic          HRESP;

  always #5 HCLK = ~HCLK;

  ahb3lite_sram_arbiter #(.HADDR_SIZE(AW), .HDATA_SIZE(DW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .REQ(REQ), .WE0(WE0), .WE1(WE1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .GNT(GNT), .DONE(DONE), .RDATA(RDATA), .ERR(ERR), .HSEL(HSEL),
    .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HTRANS(HTRANS), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(HRDATA), .HRESP(HRESP)
  );

  typedef struct {
    logic          rst;
    logic [1:0]    req;
    logic          we0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          we1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          rdy;
    logic          resp;
    logic [DW-1:0] hrd;
    logic [1:0]    gnt;
    logic [1:0]    done;
    logic          hsel;
    logic [1:0]    htrans;
    logic [AW-1:0] haddr;
    logic          hwrite;
    logic [DW-1:0] hwdata;
    logic [DW-1:0] rdata;
    logic          err;
  } vec_t;

  vec_t vecs [17];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] exp_g [4];
    int         ng;

    //          rst   req    we0   a0     d0             we1   a1     d1             rdy   resp  hrd              gnt    done   hsel  htrans haddr  hwr   hwdata         rdata          err
    vecs[0]  = '{1'b1, 2'b00, 1'b0, 8'h00, 32'h00000000, 1'b0, 8'h00, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 2'b00, 2'b00, 1'b0, 2'b00, 8'h00, 1'b0, 32'h00000000, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, 2'b01, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 8'h00, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 2'b01, 2'b00, 1'b1, 2'b10, 8'h10, 1'b1, 32'h00000000, 32'h00000000, 1'b0};
    vecs[2]  = '{1'b0, 2'b00, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 8'h00, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 2'b00, 2'b00, 1'b0, 2'b00, 8'h10, 1'b1, 32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[3]  = '{1'b0, 2'b00, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 8'h00, 32'h00000000, 1'b1, 1'b0, 32'h12345678, 2'b00, 2'b01, 1'b0, 2'b00, 8'h10, 1'b1, 32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[4]  = '{1'b0, 2'b10, 1'b0, 8'h00, 32'h00000000, 1'b0, 8'h10, 32'hAAAA5555, 1'b1, 1'b0, 32'h00000000, 2'b10, 2'b00, 1'b1, 2'b10, 8'h10, 1'b0, 32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[5]  = '{1'b0, 2'b10, 1'b0, 8'h00, 32'h00000000, 1'b0, 8'h10, 32'h11111111, 1'b1, 1'b0, 32'h00000000, 2'b00, 2'b00, 1'b0, 2'b00, 8'h10, 1'b0, 32'hAAAA5555, 32'h00000000, 1'b0};
    vecs[6]  = '{1'b0, 2'b00, 1'b0, 8'h00, 32'h00000000, 1'b0, 8'h10, 32'h11111111, 1'b1, 1'b0, 32'hDEADBEEF, 2'b00, 2'b10, 1'b0, 2'b00, 8'h10, 1'b0, 32'hAAAA5555, 32'hDEADBEEF, 1'b0};
    vecs[7]  = '{1'b0, 2'b01, 1'b1, 8'h23, 32'h0BADF00D, 1'b0, 8'h00, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 2'b01, 2'b00, 1'b1, 2'b10, 8'h20, 1'b1, 32'hAAAA5555, 32'hDEADBEEF, 1'b0};
    vecs[8]  = '{1'b0, 2'b00, 1'b1, 8'h23, 32'h00000000, 1'b0, 8'h00, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 2'b00, 2'b00, 1'b0, 2'b00, 8'h20, 1'b1, 32'h0BADF00D, 32'hDEADBEEF, 1'b0};
    vecs[9]  = '{1'b0, 2'b00, 1'b1, 8'h23, 32'h00000000, 1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 32'h55555555, 2'b00, 2'b00, 1'b0, 2'b00, 8'h20, 1'b1, 32'h0BADF00D, 32'hDEADBEEF, 1'b0};
    vecs[10] = '{1'b0, 2'b00, 1'b1, 8'h23, 32'h00000000, 1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 32'h55555555, 2'b00, 2'b00, 1'b0, 2'b00, 8'h20, 1'b1, 32'h0BADF00D, 32'hDEADBEEF, 1'b0};
    vecs[11] = '{1'b0, 2'b00, 1'b1, 8'h23, 32'h00000000, 1'b0, 8'h00, 32'h00000000, 1'b1, 1'b0, 32'h55555555, 2'b00, 2'b01, 1'b0, 2'b00, 8'h20, 1'b1, 32'h0BADF00D, 32'hDEADBEEF, 1'b0};
    vecs[12] = '{1'b0, 2'b10, 1'b0, 8'h00, 32'h00000000, 1'b0, 8'h30, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 2'b10, 2'b00, 1'b1, 2'b10, 8'h30, 1'b0, 32'h0BADF00D, 32'hDEADBEEF, 1'b0};
    vecs[13] = '{1'b0, 2'b00, 1'b0, 8'h00, 32'h00000000, 1'b0, 8'h30, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 2'b00, 2'b00, 1'b0, 2'b00, 8'h30, 1'b0, 32'h00000000, 32'hDEADBEEF, 1'b0};
    vecs[14] = '{1'b0, 2'b00, 1'b0, 8'h00, 32'h00000000, 1'b0, 8'h30, 32'h00000000, 1'b0, 1'b1, 32'hFFFFFFFF, 2'b00, 2'b00, 1'b0, 2'b00, 8'h30, 1'b0, 32'h00000000, 32'hDEADBEEF, 1'b0};
    vecs[15] = '{1'b0, 2'b00, 1'b0, 8'h00, 32'h00000000, 1'b0, 8'h30, 32'h00000000, 1'b1, 1'b1, 32'hFFFFFFFF, 2'b00, 2'b10, 1'b0, 2'b00, 8'h30, 1'b0, 32'h00000000, 32'hFFFFFFFF, 1'b1};
    vecs[16] = '{1'b0, 2'b00, 1'b0, 8'h00, 32'h00000000, 1'b0, 8'h30, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 2'b00, 2'b00, 1'b0, 2'b00, 8'h30, 1'b0, 32'h00000000, 32'hFFFFFFFF, 1'b1};

    for (int i = 0; i < 17; i++) begin
      HRESET = vecs[i].rst;
      REQ    = vecs[i].req;
      WE0    = vecs[i].we0;
      ADDR0  = vecs[i].a0;
      WDATA0 = vecs[i].d0;
      WE1    = vecs[i].we1;
      ADDR1  = vecs[i].a1;
      WDATA1 = vecs[i].d1;
      HREADY = vecs[i].rdy;
      HRESP  = vecs[i].resp;
      HRDATA = vecs[i].hrd;
      tick();
      chk($sformatf("row%0d_gnt", i),    32'(GNT),    32'(vecs[i].gnt));
      chk($sformatf("row%0d_done", i),   32'(DONE),   32'(vecs[i].done));
      chk($sformatf("row%0d_hsel", i),   32'(HSEL),   32'(vecs[i].hsel));
      chk($sformatf("row%0d_htrans", i), 32'(HTRANS), 32'(vecs[i].htrans));
      chk($sformatf("row%0d_haddr", i),  32'(HADDR),  32'(vecs[i].haddr));
      chk($sformatf("row%0d_hwrite", i), 32'(HWRITE), 32'(vecs[i].hwrite));
      chk($sformatf("row%0d_hwdata", i), HWDATA,      vecs[i].hwdata);
      chk($sformatf("row%0d_rdata", i),  RDATA,       vecs[i].rdata);
      chk($sformatf("row%0d_err", i),    32'(ERR),    32'(vecs[i].err));
      chk($sformatf("row%0d_hsize", i),  32'(HSIZE),  32'h2);
      chk($sformatf("row%0d_hburst", i), 32'(HBURST), 32'h0);
      chk($sformatf("row%0d_hprot", i),  32'(HPROT),  32'h3);
    end

    // Contention: both requesting from reset, expect 0,1,0,1 at 3-cycle spacing.
    HRESET = 1'b1; REQ = 2'b00; HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    tick();
    HRESET = 1'b0; REQ = 2'b11;
    WE0 = 1'b1; ADDR0 = 8'h40; WDATA0 = 32'hC0C0C0C0;
    WE1 = 1'b0; ADDR1 = 8'h44; WDATA1 = 32'h0;
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    ng = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      chk($sformatf("rr_overlap_c%0d", c), 32'(GNT & DONE), 32'h0);
      if (GNT != 2'b00) begin
        chk($sformatf("rr_gnt%0d", ng), 32'(GNT), 32'(exp_g[ng]));
        chk($sformatf("rr_cycle%0d", ng), 32'(c), 32'(1 + 3 * ng));
        ng++;
        if (ng == 4) break;
      end
    end
    chk("rr_grant_count", 32'(ng), 32'd4);

    // Grant requester 0 so the pointer favours 1, then reset mid-address-phase.
    REQ = 2'b00;
    tick();
    tick();
    REQ = 2'b01;
    tick();
    chk("pre_rst_gnt", 32'(GNT), 32'h1);
    chk("pre_rst_htrans", 32'(HTRANS), 32'h2);
    HRESET = 1'b1; REQ = 2'b11;
    tick();
    chk("rst_gnt", 32'(GNT), 32'h0);
    chk("rst_done", 32'(DONE), 32'h0);
    chk("rst_hsel", 32'(HSEL), 32'h0);
    chk("rst_htrans", 32'(HTRANS), 32'h0);
    chk("rst_haddr", 32'(HADDR), 32'h0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_rdata", RDATA, 32'h0);
    HRESET = 1'b0;
    tick();
    chk("post_rst_gnt", 32'(GNT), 32'h1);
    chk("post_rst_done", 32'(DONE), 32'h0);
    REQ = 2'b00;
    tick();
    chk("post_rst_done_data", 32'(DONE), 32'h0);
    tick();
    chk("post_rst_done_final", 32'(DONE), 32'h1);
    tick();
    chk("post_rst_done_pulse", 32'(DONE), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
